debounce_pb_multi: RTL and testbench
====================================

// Module: debounce_pb_multi
// PURPOSE
//  N-channel pushbutton debouncer for the Pong input path (paddle up/down, serve, reset keys).
//  Synchronises each raw button, filters bounce with a per-channel stability counter,
//  and produces a clean level plus one-cycle press/release strobes.
//  An optional hold-to-repeat strobe drives continuous paddle motion.
//  Sits between the board pins and the game FSM / paddle controllers.
// PARAMETERS
//  N_CH         4       number of independent button channels
//  STABLE_CNT   500000  consecutive cycles of stable input required to accept a change (10 ms @ 50 MHz); >= 2
//  ACTIVE_LOW   1       1: raw pin reads 0 when pressed (idle high); 0: pin reads 1 when pressed
//  REPEAT_EN    1       1: generate pb_repeat strobes while held; 0: pb_repeat tied 0
//  REPEAT_DLY   25000000 cycles from accepted press to first repeat strobe; >= 1
//  REPEAT_RATE  5000000 cycles between subsequent repeat strobes; >= 1
// PORTS
//  in_clk      in   1     system clock
//  in_rst_n    in   1     asynchronous active-low reset
//  pb_in       in   N_CH  raw, asynchronous button pins
//  pb_level    out  N_CH  debounced state, 1 = pressed (polarity-normalised)
//  pb_press    out  N_CH  one-cycle strobe on accepted press
//  pb_release  out  N_CH  one-cycle strobe on accepted release
//  pb_repeat   out  N_CH  one-cycle strobe per repeat interval while held
// BEHAVIOUR
//  - One clock, in_clk; reset is asynchronous and active-low on in_rst_n.
//  - Reset: sync FFs load the idle pin level (ACTIVE_LOW ? 1 : 0), so no press is seen at reset release.
//    Every output is 0 in reset and every counter is 0. All channels reset to IDLE.
//  - Input stage: 2-FF synchroniser per bit, then normalisation: p = ACTIVE_LOW ? ~sync : sync.
//  - Per-channel FSM, all outputs registered:
//    IDLE:   level=0. If p=1, cnt<=1 and go to PWAIT.
//    PWAIT:  if p=0, cnt<=0 and go to IDLE (bounce rejected, no strobe).
//            Else if cnt==STABLE_CNT-1, go to HELD, level<=1, pb_press<=1 for 1 cycle, rcnt<=0.
//            Else cnt++.
//    HELD:   level=1. If p=0, cnt<=1 and go to RWAIT. Otherwise the repeat logic runs.
//    RWAIT:  level stays 1. If p=1, cnt<=0 and go to HELD (repeat timing continues, not restarted).
//            Else if cnt==STABLE_CNT-1, go to IDLE, level<=0, pb_release<=1.
//            Else cnt++.
//  - Latency: a clean edge on pb_in reaches pb_level/strobe exactly 2+STABLE_CNT cycles later.
//    A glitch shorter than STABLE_CNT synchronised cycles produces no output change.
//  - Repeat (REPEAT_EN=1), evaluated in HELD and RWAIT:
//    rcnt increments each cycle.
//    First pb_repeat pulses when rcnt reaches REPEAT_DLY; rcnt then reloads, and later pulses
//    come every REPEAT_RATE cycles.
//    rcnt clears on entry to IDLE. No repeat pulse is issued in the same cycle as pb_press or pb_release.
//  - pb_press and pb_release are mutually exclusive per channel. Channels are fully independent;
//    simultaneous events on different channels are all reported in the same cycle.
//  - Counter widths: $clog2(max(STABLE_CNT, REPEAT_DLY+REPEAT_RATE)+1). Counters saturate, never wrap.
//  - Reset asserted mid-debounce or mid-hold: the channel aborts to IDLE immediately,
//    with no release strobe on exit from reset.
// STRUCTURE
//  - Sub-module debounce_ch: one channel (sync, FSM, stability counter, repeat counter),
//    instantiated N_CH times in a generate loop. The top level only wires the vectors.
//  - Shared include pong_defs.vh holds:
//    FSM state encodings (IDLE=2'd0, PWAIT=2'd1, HELD=2'd2, RWAIT=2'd3);
//    CLK_HZ=50_000_000; DEBOUNCE_MS=10.
//    STABLE_CNT and the repeat defaults are derived from these.
// TESTING  (sim params: N_CH=2, STABLE_CNT=8, REPEAT_DLY=20, REPEAT_RATE=5, ACTIVE_LOW=1, 20 ns clk)
//  1. Reset: hold in_rst_n=0 with pb_in=2'b11, then release -> all outputs 0; no strobe for 50 cycles.
//  2. Bounce: ch0 low for 3 cycles, high for 1, low for 5, then high -> pb_level[0] stays 0;
//     pb_press never asserts.
//  3. Clean press: ch0 low at cycle t -> pb_press[0]=1 only at cycle t+10 and pb_level[0]=1 from t+10.
//     Then drive ch0 high -> pb_release[0] exactly 10 cycles later.
//  4. Repeat: hold ch0 low for 60 cycles after the press is accepted -> pb_repeat[0] pulses at
//     +20, +25, +30, ... (relative to pb_press); pulses stop on release.
//  5. Release bounce while held: ch0 high for 4 cycles, then low -> no pb_release;
//     repeat cadence is not disturbed.
//  6. Multi-channel and reset abort: both channels pressed in the same cycle -> both pb_press bits set
//     together. in_rst_n pulsed low mid-hold -> levels go 0 asynchronously, with no pb_release.

Source files
------------

// File: rtl/debounce_pb_multi_pkg.sv
// Shared constants for the Pong pushbutton debouncer: timing defaults derived from the board clock,
// per-channel FSM encodings and the counter-width helper.
package debounce_pb_multi_pkg;

  localparam int unsigned CLK_HZ      = 50_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;

  localparam int unsigned STABLE_CNT_DEF  = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned REPEAT_DLY_DEF  = CLK_HZ / 2;
  localparam int unsigned REPEAT_RATE_DEF = CLK_HZ / 10;

  typedef logic [1:0] db_state_t;

  localparam db_state_t StIdle  = 2'd0;
  localparam db_state_t StPwait = 2'd1;
  localparam db_state_t StHeld  = 2'd2;
  localparam db_state_t StRwait = 2'd3;

  // Wide enough for both the stability count and a full repeat span, so neither counter wraps.
  function automatic int unsigned db_cnt_width(input int unsigned stable_cnt,
                                               input int unsigned repeat_dly,
                                               input int unsigned repeat_rate);
    int unsigned top;
    top = (stable_cnt > repeat_dly + repeat_rate) ? stable_cnt : repeat_dly + repeat_rate;
    return int'($clog2(top + 1));
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One pushbutton channel: 2-FF synchroniser, polarity normalisation, stability FSM and
// hold-to-repeat timer. All outputs are registered.
module debounce_ch
  import debounce_pb_multi_pkg::*;
#(
  parameter int unsigned STABLE_CNT  = STABLE_CNT_DEF,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_RATE = REPEAT_RATE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic level,
  output logic press_stb,
  output logic release_stb,
  output logic repeat_stb
);

  localparam int unsigned CW = db_cnt_width(STABLE_CNT, REPEAT_DLY, REPEAT_RATE);

  localparam logic          IdlePin    = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CntOne     = CW'(1);
  localparam logic [CW-1:0] CntMax     = {CW{1'b1}};
  localparam logic [CW-1:0] StableLast = CW'(STABLE_CNT - 1);
  localparam logic [CW-1:0] DlyLast    = CW'(REPEAT_DLY - 1);
  localparam logic [CW-1:0] RateLast   = CW'(REPEAT_RATE - 1);

  logic [1:0]    sync_q;
  logic          pressed;
  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic          rep_armed_q, rep_armed_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          repeat_q, repeat_d;
  logic          rep_run;
  logic [CW-1:0] rep_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{IdlePin}};
    end else begin
      sync_q <= {sync_q[0], pb_raw};
    end
  end

  assign pressed = (ACTIVE_LOW != 0) ? ~sync_q[1] : sync_q[1];

  // rep_armed_q selects the steady repeat period once the initial delay has elapsed.
  assign rep_last = rep_armed_q ? RateLast : DlyLast;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rcnt_d      = rcnt_q;
    rep_armed_d = rep_armed_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;
    rep_run     = 1'b0;

    unique case (state_q)
      StIdle: begin
        level_d     = 1'b0;
        cnt_d       = '0;
        rcnt_d      = '0;
        rep_armed_d = 1'b0;
        if (pressed) begin
          cnt_d   = CntOne;
          state_d = StPwait;
        end
      end

      StPwait: begin
        if (!pressed) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else if (cnt_q == StableLast) begin
          state_d     = StHeld;
          level_d     = 1'b1;
          press_d     = 1'b1;
          cnt_d       = '0;
          rcnt_d      = '0;
          rep_armed_d = 1'b0;
        end else begin
          cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
        end
      end

      StHeld: begin
        rep_run = 1'b1;
        if (!pressed) begin
          cnt_d   = CntOne;
          state_d = StRwait;
        end
      end

      StRwait: begin
        if (pressed) begin
          cnt_d   = '0;
          state_d = StHeld;
          rep_run = 1'b1;
        end else if (cnt_q == StableLast) begin
          // Release cycle: repeat timer is dropped so no repeat coincides with the release.
          state_d     = StIdle;
          level_d     = 1'b0;
          release_d   = 1'b1;
          cnt_d       = '0;
          rcnt_d      = '0;
          rep_armed_d = 1'b0;
        end else begin
          cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
          rep_run = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Repeat timing keeps running through release bounces so the cadence is undisturbed.
    if (rep_run && (REPEAT_EN != 0)) begin
      if (rcnt_q == rep_last) begin
        repeat_d    = 1'b1;
        rcnt_d      = '0;
        rep_armed_d = 1'b1;
      end else begin
        rcnt_d = (rcnt_q == CntMax) ? rcnt_q : rcnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      rep_armed_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      repeat_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rcnt_q      <= rcnt_d;
      rep_armed_q <= rep_armed_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      repeat_q    <= repeat_d;
    end
  end

  assign level       = level_q;
  assign press_stb   = press_q;
  assign release_stb = release_q;
  assign repeat_stb  = repeat_q;

endmodule

// File: rtl/debounce_pb_multi.sv
// N-channel pushbutton debouncer for the Pong input path; each bit is handled by an
// independent debounce_ch instance.
module debounce_pb_multi
  import debounce_pb_multi_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned STABLE_CNT  = STABLE_CNT_DEF,
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned REPEAT_EN   = 1,
  parameter int unsigned REPEAT_DLY  = REPEAT_DLY_DEF,
  parameter int unsigned REPEAT_RATE = REPEAT_RATE_DEF
) (
  input  logic            in_clk,
  input  logic            in_rst_n,
  input  logic [N_CH-1:0] pb_in,
  output logic [N_CH-1:0] pb_level,
  output logic [N_CH-1:0] pb_press,
  output logic [N_CH-1:0] pb_release,
  output logic [N_CH-1:0] pb_repeat
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .STABLE_CNT  (STABLE_CNT),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .REPEAT_EN   (REPEAT_EN),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk         (in_clk),
      .rst_n       (in_rst_n),
      .pb_raw      (pb_in[i]),
      .level       (pb_level[i]),
      .press_stb   (pb_press[i]),
      .release_stb (pb_release[i]),
      .repeat_stb  (pb_repeat[i])
    );
  end

endmodule

// File: tb/tb_debounce_pb_multi.sv
// Directed bench for debounce_pb_multi: expected strobes are queued with their due cycle when
// stimulus is applied and compared every cycle against the DUT outputs.
module tb_debounce_pb_multi;

  localparam int unsigned N_CH = 2;
  localparam int unsigned LAT  = 10;  // 2 sync stages + STABLE_CNT
  localparam int unsigned DLY  = 20;
  localparam int unsigned RATE = 5;

  localparam logic [1:0] KPress   = 2'd0;
  localparam logic [1:0] KRelease = 2'd1;
  localparam logic [1:0] KRepeat  = 2'd2;

  typedef struct {
    int unsigned cyc;
    int unsigned ch;
    logic [1:0]  kind;
  } ev_t;

  logic            in_clk;
  logic            in_rst_n;
  logic [N_CH-1:0] pb_in;
  logic [N_CH-1:0] pb_level;
  logic [N_CH-1:0] pb_press;
  logic [N_CH-1:0] pb_release;
  logic [N_CH-1:0] pb_repeat;

  ev_t             exp_q[$];
  logic [N_CH-1:0] level_exp;
  int unsigned     cyc;
  int unsigned     checks;
  int unsigned     failures;

  debounce_pb_multi #(
    .N_CH        (N_CH),
    .STABLE_CNT  (8),
    .ACTIVE_LOW  (1),
    .REPEAT_EN   (1),
    .REPEAT_DLY  (DLY),
    .REPEAT_RATE (RATE)
  ) dut (
    .in_clk     (in_clk),
    .in_rst_n   (in_rst_n),
    .pb_in      (pb_in),
    .pb_level   (pb_level),
    .pb_press   (pb_press),
    .pb_release (pb_release),
    .pb_repeat  (pb_repeat)
  );

  initial in_clk = 1'b0;
  always #10 in_clk = ~in_clk;

  task automatic check_vec(input string tag, input logic [N_CH-1:0] got,
                           input logic [N_CH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int unsigned at, input int unsigned ch, input logic [1:0] kind);
    ev_t ev;
    ev.cyc  = at;
    ev.ch   = ch;
    ev.kind = kind;
    exp_q.push_back(ev);
  endtask

  // Advance one clock, then compare every output against the events due this cycle.
  task automatic tick();
    logic [N_CH-1:0] ep, er, et;
    ev_t ev;
    @(posedge in_clk);
    cyc++;
    @(negedge in_clk);
    ep = '0;
    er = '0;
    et = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      ev = exp_q.pop_front();
      if (ev.cyc != cyc) begin
        checks++;
        failures++;
        $error("FAIL stale_event cyc=%0d observed=none expected=event@%0d", cyc, ev.cyc);
      end else begin
        case (ev.kind)
          KPress:   begin ep[ev.ch] = 1'b1; level_exp[ev.ch] = 1'b1; end
          KRelease: begin er[ev.ch] = 1'b1; level_exp[ev.ch] = 1'b0; end
          default:  et[ev.ch] = 1'b1;
        endcase
      end
    end
    check_vec("pb_press", pb_press, ep);
    check_vec("pb_release", pb_release, er);
    check_vec("pb_repeat", pb_repeat, et);
    check_vec("pb_level", pb_level, level_exp);
  endtask

  task automatic ticks(input int unsigned n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int unsigned t0, p0, rel;
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    level_exp = '0;

    // 1. Reset with idle (high) pins, then 50 quiet cycles.
    in_rst_n = 1'b0;
    pb_in    = 2'b11;
    #1;
    check_vec("reset_level", pb_level, 2'b00);
    check_vec("reset_press", pb_press, 2'b00);
    ticks(4);
    in_rst_n = 1'b1;
    ticks(50);

    // 2. Bounce on ch0: 3 low, 1 high, 5 low, then high -- never accepted.
    pb_in[0] = 1'b0; ticks(3);
    pb_in[0] = 1'b1; ticks(1);
    pb_in[0] = 1'b0; ticks(5);
    pb_in[0] = 1'b1; ticks(25);

    // 3/4. Clean press, hold for repeats, release 62 cycles after acceptance.
    t0  = cyc;
    p0  = t0 + LAT;
    rel = p0 + 62;
    push(p0, 0, KPress);
    for (int unsigned r = p0 + DLY; r < rel + LAT; r += RATE) push(r, 0, KRepeat);
    pb_in[0] = 1'b0;
    while (cyc < p0 + 40) tick();

    // 5. Release bounce while held: 4 cycles high then low again -- no release, cadence kept.
    pb_in[0] = 1'b1; ticks(4);
    pb_in[0] = 1'b0;
    while (cyc < rel) tick();

    pb_in[0] = 1'b1;
    push(cyc + LAT, 0, KRelease);
    ticks(LAT + 30);

    // 6. Both channels pressed together, then reset pulsed mid-hold.
    t0 = cyc;
    push(t0 + LAT, 0, KPress);
    push(t0 + LAT, 1, KPress);
    pb_in = 2'b00;
    while (cyc < t0 + LAT + 12) tick();
    in_rst_n = 1'b0;
    #1;
    check_vec("rst_abort_level", pb_level, 2'b00);
    check_vec("rst_abort_release", pb_release, 2'b00);
    level_exp = '0;
    pb_in     = 2'b11;
    ticks(3);
    in_rst_n = 1'b1;
    ticks(30);

    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL pending_events observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
